// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: default widths and the
// controller state encoding used by pipeline_ctrl.
package pipe_pkg;

    // Default datapath / performance counter width
    localparam int DBITS = 32;

    // Default register index width (16 architectural registers)
    localparam int REG_INDEX_BIT_WIDTH = 4;

    // Controller states:
    //   RUN     - normal flow, all hazard sources evaluated
    //   LDSTALL - second cycle of a load-use stall, hazard detection masked
    //   FLUSH   - cycle after a mispredict flush, EX holds a bubble
    //   MEMWAIT - pipeline frozen until data memory is ready
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Used for the stall and
// flush performance counters of the pipeline controller.
module sat_counter #(
    parameter int DBITS = pipe_pkg::DBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [DBITS-1:0] count
);

    logic [DBITS-1:0] count_q;
    logic [DBITS-1:0] count_d;

    // Clear wins over increment; once all-ones the count holds there
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / flush controller. Generates the PC, IF/DEC and DECreg
// write enables and bubble-insert controls from the decode/EX state, and
// counts stall and flush cycles for performance monitoring.
module pipeline_ctrl #(
    parameter int DBITS               = pipe_pkg::DBITS,
    parameter int REG_INDEX_BIT_WIDTH = pipe_pkg::REG_INDEX_BIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs1,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs2,
    input  logic                           DEC_useRs1,
    input  logic                           DEC_useRs2,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
    input  logic                           EX_wrReg,
    input  logic                           EX_isLoad,
    input  logic                           EX_mispredict,
    input  logic                           mem_busy,
    input  logic                           cnt_clr,
    output logic                           PC_wrt_en,
    output logic                           IF_wrt_en,
    output logic                           DEC_wrt_en,
    output logic                           IF_flush,
    output logic                           DEC_flush,
    output logic [DBITS-1:0]               stallCount,
    output logic [DBITS-1:0]               flushCount
);

    import pipe_pkg::state_e;
    import pipe_pkg::RUN;
    import pipe_pkg::LDSTALL;
    import pipe_pkg::FLUSH;
    import pipe_pkg::MEMWAIT;

    state_e state_q;
    state_e state_d;

    logic loadUseHazard;
    logic flushEvent;
    logic stallEvent;

    // A load in EX feeding a source the decode instruction reads; x0 never hazards
    always_comb begin
        loadUseHazard = EX_isLoad && EX_wrReg && (EX_rd != '0) &&
                        ((DEC_useRs1 && (DEC_rs1 == EX_rd)) ||
                         (DEC_useRs2 && (DEC_rs2 == EX_rd)));
    end

    // Mealy next-state and control outputs; priority mem_busy > mispredict > hazard
    always_comb begin
        state_d    = state_q;
        PC_wrt_en  = 1'b1;
        IF_wrt_en  = 1'b1;
        DEC_wrt_en = 1'b1;
        IF_flush   = 1'b0;
        DEC_flush  = 1'b0;
        flushEvent = 1'b0;

        unique case (state_q)
            // MEMWAIT releasing behaves exactly like RUN for that cycle
            RUN, MEMWAIT: begin
                if (mem_busy) begin
                    PC_wrt_en  = 1'b0;
                    IF_wrt_en  = 1'b0;
                    DEC_wrt_en = 1'b0;
                    state_d    = MEMWAIT;
                end else if (EX_mispredict) begin
                    IF_flush   = 1'b1;
                    DEC_flush  = 1'b1;
                    flushEvent = 1'b1;
                    state_d    = FLUSH;
                end else if (loadUseHazard) begin
                    PC_wrt_en  = 1'b0;
                    IF_wrt_en  = 1'b0;
                    DEC_flush  = 1'b1;
                    state_d    = LDSTALL;
                end else begin
                    state_d    = RUN;
                end
            end

            // The stalled consumer now sees the load result; only re-check mem/mispredict
            LDSTALL: begin
                if (mem_busy) begin
                    PC_wrt_en  = 1'b0;
                    IF_wrt_en  = 1'b0;
                    DEC_wrt_en = 1'b0;
                    state_d    = MEMWAIT;
                end else if (EX_mispredict) begin
                    IF_flush   = 1'b1;
                    DEC_flush  = 1'b1;
                    flushEvent = 1'b1;
                    state_d    = FLUSH;
                end else begin
                    state_d    = RUN;
                end
            end

            // EX holds the bubble just inserted, so its mispredict/hazard info is stale
            FLUSH: begin
                if (mem_busy) begin
                    PC_wrt_en  = 1'b0;
                    IF_wrt_en  = 1'b0;
                    DEC_wrt_en = 1'b0;
                    state_d    = MEMWAIT;
                end else begin
                    state_d    = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase

        stallEvent = !PC_wrt_en;
    end

    // Controller state register; reset abandons whatever was in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .DBITS (DBITS)
    ) u_stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (stallEvent),
        .clr   (cnt_clr),
        .count (stallCount)
    );

    sat_counter #(
        .DBITS (DBITS)
    ) u_flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (flushEvent),
        .clr   (cnt_clr),
        .count (flushCount)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a cycle-by-cycle vector table followed by
// hand-written sequences for memory wait, reset abort and counter saturation.
module tb_pipeline_ctrl;

    localparam int TB_DBITS = 4;
    localparam int TB_RIW   = 4;

    logic                clk;
    logic                reset;
    logic [TB_RIW-1:0]   DEC_rs1;
    logic [TB_RIW-1:0]   DEC_rs2;
    logic                DEC_useRs1;
    logic                DEC_useRs2;
    logic [TB_RIW-1:0]   EX_rd;
    logic                EX_wrReg;
    logic                EX_isLoad;
    logic                EX_mispredict;
    logic                mem_busy;
    logic                cnt_clr;
    logic                PC_wrt_en;
    logic                IF_wrt_en;
    logic                DEC_wrt_en;
    logic                IF_flush;
    logic                DEC_flush;
    logic [TB_DBITS-1:0] stallCount;
    logic [TB_DBITS-1:0] flushCount;

    logic [4:0] ctl;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic              mb;
        logic              mp;
        logic              ld;
        logic              wr;
        logic [TB_RIW-1:0] rd;
        logic [TB_RIW-1:0] rs1;
        logic              u1;
        logic [TB_RIW-1:0] rs2;
        logic              u2;
        logic              clr;
        logic [4:0]        expCtl;
        logic [3:0]        expStall;
        logic [3:0]        expFlush;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    pipeline_ctrl #(
        .DBITS               (TB_DBITS),
        .REG_INDEX_BIT_WIDTH (TB_RIW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .DEC_rs1       (DEC_rs1),
        .DEC_rs2       (DEC_rs2),
        .DEC_useRs1    (DEC_useRs1),
        .DEC_useRs2    (DEC_useRs2),
        .EX_rd         (EX_rd),
        .EX_wrReg      (EX_wrReg),
        .EX_isLoad     (EX_isLoad),
        .EX_mispredict (EX_mispredict),
        .mem_busy      (mem_busy),
        .cnt_clr       (cnt_clr),
        .PC_wrt_en     (PC_wrt_en),
        .IF_wrt_en     (IF_wrt_en),
        .DEC_wrt_en    (DEC_wrt_en),
        .IF_flush      (IF_flush),
        .DEC_flush     (DEC_flush),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    // Control outputs bundled as {PC_en, IF_en, DEC_en, IF_flush, DEC_flush}
    assign ctl = {PC_wrt_en, IF_wrt_en, DEC_wrt_en, IF_flush, DEC_flush};

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t makeVec(
        input logic mb, input logic mp, input logic ld, input logic wr,
        input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
        input logic [3:0] rs2, input logic u2, input logic clr,
        input logic [4:0] expCtl, input logic [3:0] expStall, input logic [3:0] expFlush);
        vec_t v;
        v.mb = mb; v.mp = mp; v.ld = ld; v.wr = wr;
        v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.clr = clr;
        v.expCtl = expCtl; v.expStall = expStall; v.expFlush = expFlush;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setQuiet();
        mem_busy = 1'b0; EX_mispredict = 1'b0; EX_isLoad = 1'b0; EX_wrReg = 1'b0;
        EX_rd = '0; DEC_rs1 = '0; DEC_rs2 = '0; DEC_useRs1 = 1'b0; DEC_useRs2 = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        mem_busy = v.mb; EX_mispredict = v.mp; EX_isLoad = v.ld; EX_wrReg = v.wr;
        EX_rd = v.rd; DEC_rs1 = v.rs1; DEC_useRs1 = v.u1; DEC_rs2 = v.rs2; DEC_useRs2 = v.u2;
        cnt_clr = v.clr;
    endtask

    task automatic resetDut();
        @(negedge clk);
        setQuiet();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        setQuiet();

        //                mb mp ld wr rd rs1 u1 rs2 u2 clr  ctl       sc fc
        vecs[0]  = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 0);
        vecs[1]  = makeVec(0, 0, 1, 1, 3, 3, 1, 0, 0, 0, 5'b00101, 0, 0);
        vecs[2]  = makeVec(0, 0, 1, 1, 3, 3, 1, 0, 0, 0, 5'b11100, 1, 0);
        vecs[3]  = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 1, 0);
        vecs[4]  = makeVec(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 5'b11100, 1, 0);
        vecs[5]  = makeVec(0, 0, 1, 1, 5, 5, 0, 5, 1, 0, 5'b00101, 1, 0);
        vecs[6]  = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 2, 0);
        vecs[7]  = makeVec(0, 0, 1, 1, 7, 7, 0, 2, 1, 0, 5'b11100, 2, 0);
        vecs[8]  = makeVec(0, 0, 0, 1, 7, 7, 1, 0, 0, 0, 5'b11100, 2, 0);
        vecs[9]  = makeVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2, 0);
        vecs[10] = makeVec(0, 1, 1, 1, 3, 3, 1, 0, 0, 0, 5'b11100, 2, 1);
        vecs[11] = makeVec(0, 1, 1, 1, 3, 3, 1, 0, 0, 0, 5'b11111, 2, 1);
        vecs[12] = makeVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2, 2);
        vecs[13] = makeVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 3, 2);
        vecs[14] = makeVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 4, 2);
        vecs[15] = makeVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5, 2);
        vecs[16] = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 5, 3);
        vecs[17] = makeVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5, 3);
        vecs[18] = makeVec(0, 0, 1, 1, 3, 3, 1, 0, 0, 0, 5'b00101, 6, 3);
        vecs[19] = makeVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 7, 3);
        vecs[20] = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 7, 4);
        vecs[21] = makeVec(0, 0, 1, 1, 3, 3, 1, 0, 0, 0, 5'b00101, 7, 4);
        vecs[22] = makeVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 8, 4);
        vecs[23] = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 9, 4);
        vecs[24] = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11100, 9, 4);
        vecs[25] = makeVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 0, 0);

        // Outputs while reset is held low with quiet inputs
        #2;
        checkOutput("resetCtl", 32'(ctl), 32'(5'b11100));
        checkOutput("resetStall", 32'(stallCount), 32'd0);
        checkOutput("resetFlush", 32'(flushCount), 32'd0);

        resetDut();

        // Cycle-by-cycle table: inputs after negedge, outputs checked before posedge
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].expCtl));
            checkOutput($sformatf("vec%0d stallCount", i), 32'(stallCount), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d flushCount", i), 32'(flushCount), 32'(vecs[i].expFlush));
        end

        // Three frozen cycles with a mispredict pending, then the flush on release
        resetDut();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_busy = 1'b1; EX_mispredict = 1'b1;
            #2;
            checkOutput($sformatf("memwait%0d ctl", c), 32'(ctl), 32'(5'b00000));
        end
        @(negedge clk);
        mem_busy = 1'b0; EX_mispredict = 1'b1;
        #2;
        checkOutput("memwaitRelease ctl", 32'(ctl), 32'(5'b11111));
        checkOutput("memwaitRelease stallCount", 32'(stallCount), 32'd3);
        @(negedge clk);
        setQuiet();
        #2;
        checkOutput("memwaitAfter flushCount", 32'(flushCount), 32'd1);
        checkOutput("memwaitAfter stallCount", 32'(stallCount), 32'd3);

        // Reset mid-MEMWAIT takes effect without a clock edge
        resetDut();
        @(negedge clk);
        mem_busy = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("preAbort ctl", 32'(ctl), 32'(5'b00000));
        checkOutput("preAbort stallCount", 32'(stallCount), 32'd1);
        #1;
        reset = 1'b0; mem_busy = 1'b0;
        #1;
        checkOutput("abortMemwait ctl", 32'(ctl), 32'(5'b11100));
        checkOutput("abortMemwait stallCount", 32'(stallCount), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-FLUSH returns to RUN, so a new mispredict flushes at once
        @(negedge clk);
        EX_mispredict = 1'b1;
        @(negedge clk);
        EX_mispredict = 1'b0;
        #2;
        checkOutput("preAbortFlush flushCount", 32'(flushCount), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abortFlush flushCount", 32'(flushCount), 32'd0);
        @(negedge clk);
        reset = 1'b1; EX_mispredict = 1'b1;
        #2;
        checkOutput("afterAbortFlush ctl", 32'(ctl), 32'(5'b11111));

        // Stall counter saturates at all-ones; clear beats a simultaneous stall
        resetDut();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_busy = 1'b1;
        end
        #2;
        checkOutput("stallSat", 32'(stallCount), 32'hF);
        @(negedge clk);
        #2;
        checkOutput("stallSatHold", 32'(stallCount), 32'hF);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #2;
        checkOutput("stallClear", 32'(stallCount), 32'd0);

        // Flush counter saturates under a continuous mispredict stream
        @(negedge clk);
        setQuiet();
        EX_mispredict = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
        end
        #2;
        checkOutput("flushSat", 32'(flushCount), 32'hF);
        setQuiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
